// File: rtl/ram_loader.sv
// ram_loader
// ----------
// Sits in front of the 256x16 RAM and owns its address/in/load inputs.
// While idle the CPU-side signals pass straight through to the RAM. A
// one-cycle start pulse hands the RAM port to the loader, which fills the
// RAM from a valid/ready byte stream: one count byte (0 means 2^ADDR_W
// words) followed by big-endian 16-bit words written to consecutive
// addresses starting at 0.
//
// Optional feature: define RAM_LOADER_CHECKSUM_EN to expect one trailing
// XOR checksum byte after the data and report a mismatch on err.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, begins a load when idle
//   rx_data      incoming stream byte
//   rx_valid     rx_data is valid
//   rx_ready     loader accepts a byte this cycle
//   cpu_address  CPU-side RAM address
//   cpu_in       CPU-side write data
//   cpu_load     CPU-side write enable
//   ram_address  to RAM address
//   ram_in       to RAM data in
//   ram_load     to RAM write enable
//   busy         loader owns the RAM port
//   done         one-cycle pulse when a load completes
//   err          (checksum build only) checksum mismatch, held until next start

module ram_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic              busy,
`ifdef RAM_LOADER_CHECKSUM_EN
    output logic              err,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        HI,
        LO,
        WRITE,
`ifdef RAM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   written_q;
    logic [ADDR_W:0]   written_next;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        hi_q;
    logic [7:0]        lo_q;
    logic              accept;
    logic              last_word;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
    logic              err_q;
`endif

    // The count is one bit wider than the address so that a full RAM
    // (count byte 0 -> 2^ADDR_W words) can be represented and compared.
    assign written_next = written_q + (ADDR_W+1)'(1);
    assign last_word    = (written_next == count_q);
    assign accept       = rx_valid && rx_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the ready handshake. Bytes are only taken in
    // the states that consume one, so a byte offered during IDLE, WRITE or
    // DONE simply stays pending on the stream.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CNT;
            end
            CNT: begin
                rx_ready = 1'b1;
                if (accept) state_d = HI;
            end
            HI: begin
                rx_ready = 1'b1;
                if (accept) state_d = LO;
            end
            LO: begin
                rx_ready = 1'b1;
                if (accept) state_d = WRITE;
            end
            WRITE: begin
`ifdef RAM_LOADER_CHECKSUM_EN
                state_d = last_word ? CHK : HI;
`else
                state_d = last_word ? DONE : HI;
`endif
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                if (accept) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader datapath: word count, write address, byte capture and the
    // optional running checksum. Address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            written_q <= '0;
            addr_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q    <= '0;
                        written_q <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
                        xor_q     <= '0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                CNT: begin
                    if (accept) begin
                        count_q <= (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                     : (ADDR_W+1)'(rx_data);
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_q <= rx_data;
`ifdef RAM_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ rx_data;
`endif
                    end
                end
                LO: begin
                    if (accept) begin
                        lo_q <= rx_data;
`ifdef RAM_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ rx_data;
`endif
                    end
                end
                WRITE: begin
                    addr_q    <= addr_q + ADDR_W'(1);
                    written_q <= written_next;
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) err_q <= (rx_data != xor_q);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // RAM port mux: the loader drives the RAM whenever it is busy, and any
    // CPU write attempted in that window is dropped rather than queued.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign ram_address = busy ? addr_q : cpu_address;
    assign ram_in      = busy ? DATA_W'({hi_q, lo_q}) : cpu_in;
    assign ram_load    = busy ? (state_q == WRITE) : cpu_load;
`ifdef RAM_LOADER_CHECKSUM_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
// -------------
// Self-checking bench for ram_loader. Every word the bench streams in is
// pushed as an expected {address, data} write onto a scoreboard queue; a
// monitor pops and compares each RAM write the loader produces. A small
// behavioural RAM records all writes so final contents can be inspected.
// The checksum scenarios are compiled in when RAM_LOADER_CHECKSUM_EN is set.

module tb_ram_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_in;
    logic              cpu_load;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic              busy;
    logic              done;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic              err;
`endif

    int checks;
    int passes;
    int done_count;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];

    ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cpu_address (cpu_address),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .busy        (busy),
`ifdef RAM_LOADER_CHECKSUM_EN
        .err         (err),
`endif
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM fed by the loader's RAM port.
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    // Scoreboard monitor: every loader-owned write must match the next
    // expected word, and no byte may be taken during a write cycle.
    always @(negedge clk) begin
        if (rst_n && busy && ram_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL sb_write: unexpected write addr=%h data=%h, required none",
                         ram_address, ram_in);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({ram_address, ram_in} !== e)
                    $display("[TB] FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_address, ram_in, e[DATA_W+:ADDR_W], e[DATA_W-1:0]);
                else
                    passes++;
            end
            checks++;
            if (rx_ready !== 1'b0)
                $display("[TB] FAIL ready_in_write: rx_ready=%b, required 0", rx_ready);
            else
                passes++;
        end
        if (rst_n && done) done_count++;
    end

    // Called at a negedge; presents a byte and returns at the negedge
    // following the clock edge that accepted it. rx_valid is left high.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("[TB] FAIL byte_timeout: rx_ready=%b, required 1 within 200 cycles", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input int a, input logic [15:0] d);
        exp_q.push_back({a[ADDR_W-1:0], d});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_address = 8'h05; cpu_in = 16'h1111; cpu_load = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, required 0", done); else passes++;
        checks++; if (rx_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b, required 0", rx_ready); else passes++;
        checks++;
        if ({ram_address, ram_in, ram_load} !== {8'h05, 16'h1111, 1'b1})
            $display("[TB] FAIL passthrough: got %h/%h/%b, required 05/1111/1", ram_address, ram_in, ram_load);
        else passes++;
        cpu_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int d0;
        d0 = done_count;
        push_word(0, 16'h1234);
        push_word(1, 16'hABCD);
        rx_data = 8'h02; rx_valid = 1'b1; start = 1'b1;
        checks++; if (rx_ready !== 1'b0) $display("[TB] FAIL start_ready: got %b, required 0", rx_ready); else passes++;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if ({ram_load, ram_address, ram_in} !== {1'b1, 8'h00, 16'h1234})
            $display("[TB] FAIL write0_latency: got %b/%h/%h, required 1/00/1234", ram_load, ram_address, ram_in);
        else passes++;
        send_byte(8'hAB);
        send_byte(8'hCD);
        rx_valid = 1'b0;
        checks++;
        if ({ram_load, ram_address, ram_in} !== {1'b1, 8'h01, 16'hABCD})
            $display("[TB] FAIL write1_latency: got %b/%h/%h, required 1/01/ABCD", ram_load, ram_address, ram_in);
        else passes++;
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b11) $display("[TB] FAIL done_pulse: got done/busy=%b, required 11", {done, busy}); else passes++;
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) $display("[TB] FAIL busy_fall: got done/busy=%b, required 00", {done, busy}); else passes++;
        checks++; if (done_count - d0 !== 1) $display("[TB] FAIL done_once: got %0d pulses, required 1", done_count - d0); else passes++;
        checks++;
        if ({mem[0], mem[1]} !== {16'h1234, 16'hABCD})
            $display("[TB] FAIL basic_mem: got %h %h, required 1234 ABCD", mem[0], mem[1]);
        else passes++;
    endtask

    task automatic test_full_load();
        int d0;
        logic [15:0] w;
        d0 = done_count;
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            w = {i[7:0], ~i[7:0]};
            push_word(i, w);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        rx_valid = 1'b0;
        checks++; if (ram_address !== 8'hFF) $display("[TB] FAIL last_addr: got %h, required FF", ram_address); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL full_done: got %b, required 1", done); else passes++;
        checks++; if (mem[255] !== 16'hFF00) $display("[TB] FAIL full_m255: got %h, required FF00", mem[255]); else passes++;
        checks++; if (mem[0] !== 16'h00FF) $display("[TB] FAIL full_m0: got %h, required 00FF", mem[0]); else passes++;
        @(negedge clk);
        checks++; if (done_count - d0 !== 1) $display("[TB] FAIL full_done_once: got %0d, required 1", done_count - d0); else passes++;
    endtask

    task automatic test_back_to_back(input bit gaps);
        logic [7:0] bytes [0:6];
        bytes[0] = 8'h03; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33;
        bytes[4] = 8'h44; bytes[5] = 8'h55; bytes[6] = 8'h66;
        push_word(0, 16'h1122);
        push_word(1, 16'h3344);
        push_word(2, 16'h5566);
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            if (gaps) begin
                rx_valid = 1'b0;
                repeat (10) @(negedge clk);
            end
            send_byte(bytes[i]);
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem[0], mem[1], mem[2]} !== {16'h1122, 16'h3344, 16'h5566})
            $display("[TB] FAIL stream_mem gaps=%0d: got %h %h %h, required 1122 3344 5566",
                     gaps, mem[0], mem[1], mem[2]);
        else passes++;
    endtask

    task automatic test_cpu_blocked();
        push_word(0, 16'hC0DE);
        cpu_address = 8'h00; cpu_in = 16'hDEAD; cpu_load = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hC0);
        send_byte(8'hDE);
        rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL cpu_done: got %b, required 1", done); else passes++;
        checks++; if (mem[0] !== 16'hC0DE) $display("[TB] FAIL cpu_dropped: got %h, required C0DE", mem[0]); else passes++;
        @(negedge clk);
        checks++;
        if ({busy, ram_load, ram_address, ram_in} !== {1'b0, 1'b1, 8'h00, 16'hDEAD})
            $display("[TB] FAIL cpu_after: got %b/%b/%h/%h, required 0/1/00/DEAD", busy, ram_load, ram_address, ram_in);
        else passes++;
        @(negedge clk);
        cpu_load = 1'b0;
        checks++; if (mem[0] !== 16'hDEAD) $display("[TB] FAIL cpu_write: got %h, required DEAD", mem[0]); else passes++;
    endtask

    task automatic test_reset_mid_load();
        int d0;
        d0 = done_count;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        rx_data = 8'hBB;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ram_load, done, rx_ready} !== 4'b0000)
            $display("[TB] FAIL mid_reset: got busy/load/done/ready=%b, required 0000", {busy, ram_load, done, rx_ready});
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({busy, rx_ready} !== 2'b00) $display("[TB] FAIL after_reset: got busy/ready=%b, required 00", {busy, rx_ready}); else passes++;
        checks++; if (done_count !== d0) $display("[TB] FAIL reset_no_done: got %0d, required %0d", done_count, d0); else passes++;
    endtask

`ifdef RAM_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] ck, input logic exp_err);
        push_word(0, 16'h1234);
        pulse_start();
        checks++; if (err !== 1'b0) $display("[TB] FAIL err_clear: got %b, required 0", err); else passes++;
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(ck);
        rx_valid = 1'b0;
        checks++; if (done !== 1'b1) $display("[TB] FAIL chk_done: got %b, required 1", done); else passes++;
        @(negedge clk);
        checks++; if (err !== exp_err) $display("[TB] FAIL checksum_err: got %b, required %b", err, exp_err); else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        done_count = 0;
        test_reset();
        test_basic_load();
        test_full_load();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_cpu_blocked();
        test_reset_mid_load();
`ifdef RAM_LOADER_CHECKSUM_EN
        test_checksum(8'h26, 1'b0);
        test_checksum(8'h27, 1'b1);
`endif
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL sb_empty: %0d writes missing, required 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
